// File: rtl/srio_pkg.sv
// srio_pkg: shared SRIO constants, HELLO header field offsets, packer state encodings and length helpers
package srio_pkg;
  localparam logic [3:0] FTYPE_SWRITE = 4'h6;
  localparam logic [3:0] TTYPE_SWRITE = 4'h0;
  localparam int TID_LSB   = 56;
  localparam int FTYPE_LSB = 52;
  localparam int TTYPE_LSB = 48;
  localparam int PRIO_LSB  = 45;
  localparam int SIZE_LSB  = 36;
  localparam int ADDR_LSB  = 0;
  localparam int MAX_PKT_WORDS = 32;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;
  // A zero or out-of-range word count means a full-size packet.
  function automatic logic [5:0] eff_len(input logic [5:0] p);
    return (p == 6'd0 || p > 6'(MAX_PKT_WORDS)) ? 6'(MAX_PKT_WORDS) : p;
  endfunction
  // HELLO size field is bytes minus one, truncated to 8 bits (32 words -> 255).
  function automatic logic [7:0] size_field(input logic [5:0] n);
    logic [8:0] b;
    b = {n, 3'b000} - 9'd1;
    return b[7:0];
  endfunction
endpackage

// File: rtl/srio_hello_hdr_build.sv
// srio_hello_hdr_build: combinational SRIO HELLO SWRITE header assembly
module srio_hello_hdr_build
  import srio_pkg::*;
(
  input  logic [7:0]  tid,
  input  logic [1:0]  prio,
  input  logic [7:0]  size,
  input  logic [31:0] addr,
  output logic [63:0] hdr
);
  // Place each field at its HELLO offset; all reserved bits stay zero.
  always_comb begin
    hdr = '0;
    hdr[TID_LSB +: 8]   = tid;
    hdr[FTYPE_LSB +: 4] = FTYPE_SWRITE;
    hdr[TTYPE_LSB +: 4] = TTYPE_SWRITE;
    hdr[PRIO_LSB +: 2]  = prio;
    hdr[SIZE_LSB +: 8]  = size;
    hdr[ADDR_LSB +: 34] = {2'b00, addr};
  end
endmodule

// File: rtl/srio_swrite_pack_logic.sv
// srio_swrite_pack_logic: packs AXIS payload packets into SRIO HELLO SWRITE packets
module srio_swrite_pack_logic
  import srio_pkg::*;
(
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  input  logic [3:0]  S_AXIS_TDEST,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] cmd,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1,
  input  logic [31:0] pkt_len,
  output logic [31:0] status
);
  logic [1:0]  state;
  logic [5:0]  len, cnt, cnt_nx, len_in;
  logic [7:0]  tid, size;
  logic [15:0] sent;
  logic [31:0] addr_sel;
  logic [63:0] hdr;
  logic        err_short, err_long, err_dest, hdr_out, out_free, dest_ok, accept;
  logic        unused_bits;
  assign out_free      = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign dest_ok       = S_AXIS_TDEST < 4'd2;
  assign accept        = state == ST_PAYLOAD && out_free && S_AXIS_TVALID;
  assign cnt_nx        = cnt + 6'd1;
  assign len_in        = eff_len(pkt_len[5:0]);
  assign size          = size_field(len_in);
  assign addr_sel      = S_AXIS_TDEST[0] ? addr_1 : addr_0;
  assign S_AXIS_TREADY = (state == ST_PAYLOAD && out_free) || state == ST_DROP;
  assign status        = {sent, tid, 4'h0, err_dest, err_long, err_short, state != ST_IDLE};
  assign unused_bits   = ^{cmd[31:10], cmd[7:2], pkt_len[31:6]};
  srio_hello_hdr_build u_hdr (
    .tid  (tid),
    .prio (cmd[9:8]),
    .size (size),
    .addr (addr_sel),
    .hdr  (hdr)
  );
  // Packet FSM plus the one-entry output register; header TID/count advance only when the header leaves.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET)
    if (AXIS_ARESET) begin
      state         <= ST_IDLE;
      len           <= '0;
      cnt           <= '0;
      tid           <= '0;
      sent          <= '0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_dest      <= 1'b0;
      hdr_out       <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (cmd[1]) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_dest      <= 1'b0;
      hdr_out       <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
        hdr_out       <= 1'b0;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY && hdr_out) begin
        tid  <= tid + 8'd1;
        sent <= sent + 16'd1;
      end
      if (state == ST_IDLE && cmd[0])
        state <= ST_HDR;
      if (state == ST_HDR && S_AXIS_TVALID && !dest_ok) begin
        err_dest <= 1'b1;
        state    <= ST_DROP;
      end
      if (state == ST_HDR && S_AXIS_TVALID && dest_ok && out_free) begin
        M_AXIS_TDATA  <= hdr;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= 1'b0;
        hdr_out       <= 1'b1;
        len           <= len_in;
        cnt           <= '0;
        state         <= ST_PAYLOAD;
      end
      if (accept) begin
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= S_AXIS_TLAST || cnt_nx == len;
        cnt           <= cnt_nx;
        if (S_AXIS_TLAST) begin
          state <= ST_HDR;
          if (cnt_nx < len) err_short <= 1'b1;
        end else if (cnt_nx == len) begin
          err_long <= 1'b1;
          state    <= ST_DROP;
        end
      end
      if (state == ST_DROP && S_AXIS_TVALID && S_AXIS_TLAST)
        state <= ST_HDR;
    end
endmodule

// File: tb/tb_srio_swrite_pack_logic.sv
// tb_srio_swrite_pack_logic: randomized packet-level reference model and checks for the SWRITE packer
module tb_srio_swrite_pack_logic;
  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;
  logic        clk, rst;
  logic [63:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [3:0]  S_AXIS_TDEST;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [31:0] cmd, addr_0, addr_1, pkt_len, status;
  int          vectors = 0, errors = 0, cyc = 0, t_start = 0;
  int          m_tid = 0, m_sent = 0;
  logic        m_es = 0, m_el = 0, m_ed = 0;
  logic        mon_en = 0, rdy_mode = 1, prev_stall = 0, prev_l = 0;
  logic [63:0] prev_d = '0;
  beat_t       exp_q[$], act_log[$];
  int          stamps[$];

  srio_swrite_pack_logic dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TDEST  (S_AXIS_TDEST),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .cmd           (cmd),
    .addr_0        (addr_0),
    .addr_1        (addr_1),
    .pkt_len       (pkt_len),
    .status        (status)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    M_AXIS_TREADY = 0;
    forever begin
      @(negedge clk);
      M_AXIS_TREADY = rdy_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [64:0] exp_status();
    return 65'({16'(m_sent), 8'(m_tid), 4'h0, m_ed, m_el, m_es, 1'b1});
  endfunction

  // Output monitor: every accepted output beat is checked against the model queue; stalled beats must hold.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (prev_stall) chk("hold", {M_AXIS_TDATA, M_AXIS_TLAST}, {prev_d, prev_l});
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          act_log.push_back('{M_AXIS_TDATA, M_AXIS_TLAST});
          stamps.push_back(cyc);
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL out_beat: got unexpected beat %h, want none", M_AXIS_TDATA);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 65'(M_AXIS_TDATA), 65'(e.d));
            chk("out_last", 65'(M_AXIS_TLAST), 65'(e.l));
          end
        end
      end
      prev_stall = mon_en && M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_d = M_AXIS_TDATA;
      prev_l = M_AXIS_TLAST;
    end
  end

  task automatic put_beat(input logic [63:0] d, input logic l, input logic [3:0] dst);
    int k;
    logic r;
    S_AXIS_TDATA = d;
    S_AXIS_TLAST = l;
    S_AXIS_TDEST = dst;
    S_AXIS_TVALID = 1;
    for (k = 0; k < 1000; k++) begin
      #1;
      r = S_AXIS_TREADY;
      @(negedge clk);
      if (r) break;
    end
    S_AXIS_TVALID = 0;
    if (k == 1000) begin
      vectors++;
      errors++;
      $display("FAIL in_beat_timeout: got no TREADY in 1000 cycles, want acceptance");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1);
    end
  endtask

  // Model one input packet at transaction level, drive it, then drain and compare status.
  task automatic send_pkt(input int n, input logic [3:0] dst, input logic [5:0] plen,
                          input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] pr, input bit gaps);
    logic [63:0] d[$];
    logic [63:0] h;
    logic [31:0] ad;
    int L, ob, k;
    pkt_len = {26'($urandom), plen};
    addr_0 = a0;
    addr_1 = a1;
    cmd = {22'($urandom), pr, 6'($urandom), 2'b01};
    for (int i = 0; i < n; i++) d.push_back({$urandom, $urandom});
    L = (plen == 0) ? 32 : int'(plen);
    if (dst > 4'd1) m_ed = 1;
    else begin
      ad = dst[0] ? a1 : a0;
      h = (64'(m_tid) << 56) | (64'h6 << 52) | (64'(pr) << 45) | (64'((L * 8 - 1) % 256) << 36) | 64'(ad);
      exp_q.push_back('{h, 1'b0});
      ob = (n < L) ? n : L;
      for (int i = 0; i < ob; i++) exp_q.push_back('{d[i], i == ob - 1});
      if (n < L) m_es = 1;
      if (n > L) m_el = 1;
      m_tid = (m_tid + 1) % 256;
      m_sent = (m_sent + 1) % 65536;
    end
    t_start = cyc;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      put_beat(d[i], i == n - 1, (i == 0) ? dst : 4'($urandom));
      if (i == 0) begin
        pkt_len = $urandom;
        addr_0 = $urandom;
        addr_1 = $urandom;
      end
    end
    for (k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #2;
    chk("status", 65'(status), exp_status());
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    cmd = 0;
    addr_0 = 0;
    addr_1 = 0;
    pkt_len = 0;
    S_AXIS_TDATA = 0;
    S_AXIS_TVALID = 0;
    S_AXIS_TLAST = 0;
    S_AXIS_TDEST = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #2;
    chk("reset_status", 65'(status), 65'(0));
    chk("reset_out", 65'({M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY}), 65'(0));
    chk("reset_data", 65'(M_AXIS_TDATA), 65'(0));
    cmd = 32'h1;
    @(negedge clk);
    #2;
    chk("start_busy", 65'(status[0]), 65'(1));
    @(negedge clk);
    mon_en = 1;

    rdy_mode = 1;
    act_log.delete();
    stamps.delete();
    send_pkt(4, 4'd0, 6'd4, 32'h1000, 32'h2000, 2'd1, 0);
    chk("t34_beats", 65'(act_log.size()), 65'(5));
    if (act_log.size() == 5) begin
      chk("t34_hdr", 65'(act_log[0].d), 65'(64'h0060_21F0_0000_1000));
      chk("t34_last", 65'({act_log[3].l, act_log[4].l}), 65'(2'b01));
      chk("t34_lat", 65'(stamps[0] - t_start), 65'(1));
      for (int i = 1; i < 5; i++) chk("t34_gap", 65'(stamps[i] - stamps[i - 1]), 65'(1));
    end

    rdy_mode = 0;
    act_log.delete();
    send_pkt(4, 4'd1, 6'd4, 32'h1000, 32'h2000, 2'd1, 1);
    chk("t35_beats", 65'(act_log.size()), 65'(5));
    if (act_log.size() > 0) chk("t35_tid", 65'(act_log[0].d[63:56]), 65'(1));

    act_log.delete();
    send_pkt(2, 4'd0, 6'd4, 32'h3000, 32'h4000, 2'd2, 1);
    chk("t36_beats", 65'(act_log.size()), 65'(3));
    if (act_log.size() == 3) chk("t36_last", 65'(act_log[2].l), 65'(1));
    chk("t36_short", 65'(status[1]), 65'(1));

    act_log.delete();
    send_pkt(5, 4'd0, 6'd2, 32'h5000, 32'h6000, 2'd0, 1);
    chk("t37_beats", 65'(act_log.size()), 65'(3));
    if (act_log.size() == 3) chk("t37_last", 65'(act_log[2].l), 65'(1));
    chk("t37_long", 65'(status[2]), 65'(1));
    act_log.delete();
    send_pkt(3, 4'd1, 6'd3, 32'h7000, 32'h8000, 2'd3, 1);
    chk("t37_next", 65'(act_log.size()), 65'(4));

    act_log.delete();
    send_pkt(3, 4'd5, 6'd4, 32'h9000, 32'hA000, 2'd0, 1);
    chk("t38_none", 65'(act_log.size()), 65'(0));
    chk("t38_dest", 65'(status[3]), 65'(1));
    act_log.delete();
    send_pkt(2, 4'd0, 6'd2, 32'hB000, 32'hC000, 2'd1, 1);
    chk("t38_next", 65'(act_log.size()), 65'(3));

    for (int p = 0; p < 40; p++) begin
      int n;
      logic [3:0] dst;
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(28, 34) : $urandom_range(1, 8);
      dst = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      send_pkt(n, dst, 6'($urandom_range(0, 32)), $urandom, $urandom, 2'($urandom), 1);
    end

    mon_en = 0;
    rdy_mode = 1;
    @(negedge clk);
    pkt_len = 32'd8;
    cmd = {22'd0, 2'd2, 6'd0, 2'b01};
    put_beat(64'h1111, 0, 4'd0);
    put_beat(64'h2222, 0, 4'd0);
    m_tid = (m_tid + 1) % 256;
    m_sent = (m_sent + 1) % 65536;
    cmd[1] = 1;
    @(negedge clk);
    #2;
    chk("sr_valid", 65'(M_AXIS_TVALID), 65'(0));
    chk("sr_status", 65'(status), 65'({16'(m_sent), 8'(m_tid), 8'h00}));
    cmd[1] = 0;
    m_es = 0;
    m_el = 0;
    m_ed = 0;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1;
    rdy_mode = 0;
    send_pkt(3, 4'd0, 6'd3, 32'hD000, 32'hE000, 2'd1, 1);

    mon_en = 0;
    rdy_mode = 1;
    @(negedge clk);
    pkt_len = 32'd4;
    put_beat(64'h3333, 0, 4'd0);
    #3 rst = 1;
    #1;
    chk("ar_out", 65'({M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY}), 65'(0));
    chk("ar_data", 65'(M_AXIS_TDATA), 65'(0));
    chk("ar_status", 65'(status), 65'(0));
    @(negedge clk);
    rst = 0;
    m_tid = 0;
    m_sent = 0;
    exp_q.delete();
    @(negedge clk);
    #2;
    chk("ar_restart", 65'(status[0]), 65'(1));
    @(negedge clk);
    mon_en = 1;
    act_log.delete();
    send_pkt(4, 4'd0, 6'd4, 32'hF000, 32'h1234, 2'd0, 0);
    if (act_log.size() > 0) chk("ar_tid", 65'(act_log[0].d[63:56]), 65'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
